// File: rtl/proc_param_if.sv
// Word-addressed req/ack memory bus between proc_param and its instruction/data memory.
interface proc_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/proc_param.sv
// Parametrised multi-cycle processor core: 16-bit instructions fetched over a req/ack
// memory bus, register file, output port and sticky illegal-opcode flag.
module proc_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    proc_param_if.master      mem,
    output logic [DATA_W-1:0] out,
    output logic              outen,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] x1
);
    localparam int RW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        HALTED = 3'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_OUTI   = 4'h1,
        OP_OUTLOC = 4'h2,
        OP_LI     = 4'h3,
        OP_OUTR   = 4'h4,
        OP_ADDI   = 4'h5,
        OP_LD     = 4'h6,
        OP_ST     = 4'h7,
        OP_BNZ    = 4'h8,
        OP_JMP    = 4'h9,
        OP_HALT   = 4'hF
    } op_t;

    state_t            state_q, state_d;
    logic [15:0]       instr;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]        op;
    logic [7:0]        imm;
    logic [RW-1:0]     ridx;
    logic [DATA_W-1:0] rval, imm_z, imm_s;
    logic [ADDR_W-1:0] pc_inc, imm_a;

    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] out_d, reg_wd;
    logic              outen_d, illegal_d, reg_we, instr_ld;

    assign op     = instr[11:8];
    assign imm    = instr[7:0];
    assign ridx   = instr[12 +: RW];
    assign rval   = regs[ridx];
    assign imm_z  = DATA_W'(imm);
    assign imm_s  = {{(DATA_W-8){imm[7]}}, imm};
    assign imm_a  = ADDR_W'(imm);
    assign pc_inc = pc + ADDR_W'(1);

    // Bus fields derive only from state, pc and the latched instruction, all frozen
    // while a request waits, so they stay stable until ack without extra registers.
    assign mem.mem_req   = !rst && (state_q == FETCH || state_q == MEM);
    assign mem.mem_we    = (state_q == MEM) && (op == OP_ST);
    assign mem.mem_addr  = (state_q == MEM) ? imm_a : pc;
    assign mem.mem_wdata = rval;

    assign state  = state_q;
    assign halted = (state_q == HALTED);
    assign x1     = regs[1];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        out_d     = out;
        outen_d   = 1'b0;
        illegal_d = illegal;
        reg_we    = 1'b0;
        reg_wd    = imm_z;
        instr_ld  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem.mem_ack) begin
                    instr_ld = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_NOP: ;
                    OP_OUTI: begin
                        out_d   = imm_z;
                        outen_d = 1'b1;
                    end
                    OP_OUTLOC, OP_LD, OP_ST: begin
                        state_d = MEM;
                        pc_d    = pc;
                    end
                    OP_LI: reg_we = 1'b1;
                    OP_OUTR: begin
                        out_d   = rval;
                        outen_d = 1'b1;
                    end
                    OP_ADDI: begin
                        reg_we = 1'b1;
                        reg_wd = rval + imm_s;
                    end
                    OP_BNZ:  if (rval != '0) pc_d = imm_a;
                    OP_JMP:  pc_d = imm_a;
                    OP_HALT: begin
                        state_d = HALTED;
                        pc_d    = pc;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            MEM: begin
                if (mem.mem_ack) begin
                    state_d = FETCH;
                    pc_d    = pc_inc;
                    if (op == OP_OUTLOC) begin
                        out_d   = mem.mem_rdata;
                        outen_d = 1'b1;
                    end
                    if (op == OP_LD) begin
                        reg_we = 1'b1;
                        reg_wd = mem.mem_rdata;
                    end
                end
            end
            HALTED: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc      <= '0;
            instr   <= '0;
            out     <= '0;
            outen   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            out     <= out_d;
            outen   <= outen_d;
            illegal <= illegal_d;
            if (instr_ld) instr <= mem.mem_rdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[ridx] <= reg_wd;
        end
    end
endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param: two configurations driven by memory models, checked against an
// instruction-level interpreter of the program image.
module tb_proc_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          cfg = 0;
    logic        rand_mode = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] img [256];
    int          n_checks = 0;
    int          n_errors = 0;

    proc_param_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    proc_param_if #(.DATA_W(32), .ADDR_W(4))  bus1 ();

    logic [15:0] out0, x10, pc0;
    logic        outen0, halted0, illegal0;
    logic [2:0]  state0;
    logic [31:0] out1, x11;
    logic [3:0]  pc1;
    logic        outen1, halted1, illegal1;
    logic [2:0]  state1;

    proc_param #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(16)) dut0 (
        .clk(clk), .rst(rst), .mem(bus0.master), .out(out0), .outen(outen0), .pc(pc0),
        .state(state0), .halted(halted0), .illegal(illegal0), .x1(x10)
    );

    proc_param #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(4)) dut1 (
        .clk(clk), .rst(rst), .mem(bus1.master), .out(out1), .outen(outen1), .pc(pc1),
        .state(state1), .halted(halted1), .illegal(illegal1), .x1(x11)
    );

    // Memory models: image reloaded during reset, random 0-3 wait states when rand_mode,
    // and writes stalled indefinitely while hold is set.
    logic [15:0] mem0 [256];
    int unsigned wait0 = 0;
    assign bus0.mem_ack   = bus0.mem_req && (wait0 == 0) && !(hold && bus0.mem_we);
    assign bus0.mem_rdata = mem0[bus0.mem_addr[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem0[i] <= img[i][15:0];
            wait0 <= rand_mode ? $urandom_range(0, 3) : 0;
        end else if (bus0.mem_req && bus0.mem_ack) begin
            if (bus0.mem_we) mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
            wait0 <= rand_mode ? $urandom_range(0, 3) : 0;
        end else if (bus0.mem_req && wait0 != 0) begin
            wait0 <= wait0 - 1;
        end
    end

    logic [31:0] mem1 [16];
    int unsigned wait1 = 0;
    assign bus1.mem_ack   = bus1.mem_req && (wait1 == 0) && !(hold && bus1.mem_we);
    assign bus1.mem_rdata = mem1[bus1.mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem1[i] <= img[i];
            wait1 <= rand_mode ? $urandom_range(0, 3) : 0;
        end else if (bus1.mem_req && bus1.mem_ack) begin
            if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
            wait1 <= rand_mode ? $urandom_range(0, 3) : 0;
        end else if (bus1.mem_req && wait1 != 0) begin
            wait1 <= wait1 - 1;
        end
    end

    logic [31:0] t_out, t_x1, t_wdata;
    logic [15:0] t_pc, t_addr;
    logic [2:0]  t_state;
    logic        t_outen, t_halted, t_illegal, t_req, t_ack, t_we;
    always_comb begin
        if (cfg == 0) begin
            t_out = 32'(out0); t_x1 = 32'(x10); t_pc = pc0; t_state = state0;
            t_outen = outen0; t_halted = halted0; t_illegal = illegal0;
            t_req = bus0.mem_req; t_ack = bus0.mem_ack; t_we = bus0.mem_we;
            t_addr = bus0.mem_addr; t_wdata = 32'(bus0.mem_wdata);
        end else begin
            t_out = out1; t_x1 = x11; t_pc = 16'(pc1); t_state = state1;
            t_outen = outen1; t_halted = halted1; t_illegal = illegal1;
            t_req = bus1.mem_req; t_ack = bus1.mem_ack; t_we = bus1.mem_we;
            t_addr = 16'(bus1.mem_addr); t_wdata = bus1.mem_wdata;
        end
    end

    // Bus/output monitor for the active configuration.
    logic [31:0] obs_q [$];
    int          wr_cnt = 0, stab_err = 0;
    logic [15:0] wr_addr = '0, p_addr = '0;
    logic [31:0] wr_data = '0, p_wdata = '0;
    logic        pend = 1'b0, p_we = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            obs_q.delete();
            wr_cnt <= 0; stab_err <= 0; pend <= 1'b0;
        end else begin
            if (t_outen) obs_q.push_back(t_out);
            if (t_req && t_ack && t_we) begin
                wr_cnt <= wr_cnt + 1; wr_addr <= t_addr; wr_data <= t_wdata;
            end
            if (pend && (t_addr !== p_addr || t_we !== p_we || (t_we && t_wdata !== p_wdata)))
                stab_err <= stab_err + 1;
            pend <= t_req && !t_ack; p_addr <= t_addr; p_we <= t_we; p_wdata <= t_wdata;
        end
    end

    // Reference interpreter: executes the image one instruction at a time, charging
    // 2 cycles per instruction (3 for memory ops), stopping at HALT or the cycle budget.
    logic [31:0] m_q [$];
    int unsigned m_pc, m_cycles, m_wr, m_wa;
    logic [31:0] m_x1, m_wd;
    logic        m_halted, m_illegal;

    task automatic model(input int unsigned budget);
        logic [31:0] regs [16];
        logic [31:0] mm [256];
        logic [31:0] mask;
        logic [15:0] ins;
        logic [7:0]  imm;
        logic [3:0]  op;
        int unsigned r, a, lat, nr, amod;
        logic        taken;
        nr   = (cfg == 0) ? 16 : 4;
        amod = (cfg == 0) ? 65536 : 16;
        mask = (cfg == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        for (int i = 0; i < 256; i++) mm[i] = img[i] & mask;
        m_q.delete();
        m_pc = 0; m_cycles = 0; m_wr = 0; m_wa = 0; m_wd = '0;
        m_halted = 1'b0; m_illegal = 1'b0;
        while (!m_halted) begin
            ins = mm[m_pc % 256][15:0];
            op  = ins[11:8];
            imm = ins[7:0];
            r   = ins[15:12] % nr;
            a   = imm % amod;
            lat = (op inside {4'h2, 4'h6, 4'h7}) ? 3 : 2;
            if (m_cycles + lat > budget) break;
            m_cycles += lat;
            taken = 1'b0;
            case (op)
                4'h0: ;
                4'h1: m_q.push_back(32'(imm));
                4'h2: m_q.push_back(mm[a]);
                4'h3: regs[r] = 32'(imm);
                4'h4: m_q.push_back(regs[r]);
                4'h5: regs[r] = (regs[r] + {{24{imm[7]}}, imm}) & mask;
                4'h6: regs[r] = mm[a];
                4'h7: begin mm[a] = regs[r]; m_wr++; m_wa = a; m_wd = regs[r]; end
                4'h8: taken = (regs[r] != 0);
                4'h9: taken = 1'b1;
                4'hF: m_halted = 1'b1;
                default: m_illegal = 1'b1;
            endcase
            if (taken) m_pc = a;
            else if (!m_halted) m_pc = (m_pc + 1) % amod;
        end
        m_x1 = regs[1];
    endtask

    int run_cyc;

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = '0;
    endtask

    task automatic run_prog(input int budget);
        model(budget);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_cyc = 0;
        while (!t_halted && run_cyc < budget) begin
            @(posedge clk); #1;
            run_cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (t_pc !== 16'h0) begin n_errors++; $display("FAIL cfg%0d reset_pc: got %0h want 0", cfg, t_pc); end
        n_checks++; if (t_out !== 32'h0) begin n_errors++; $display("FAIL cfg%0d reset_out: got %0h want 0", cfg, t_out); end
        n_checks++; if (t_outen !== 1'b0) begin n_errors++; $display("FAIL cfg%0d reset_outen: got %b want 0", cfg, t_outen); end
        n_checks++; if (t_state !== 3'd0) begin n_errors++; $display("FAIL cfg%0d reset_state: got %0d want 0", cfg, t_state); end
        n_checks++; if (t_halted !== 1'b0 || t_illegal !== 1'b0) begin n_errors++; $display("FAIL cfg%0d reset_flags: got %b%b want 00", cfg, t_halted, t_illegal); end
        n_checks++; if (t_req !== 1'b0 || t_we !== 1'b0) begin n_errors++; $display("FAIL cfg%0d reset_bus: got req=%b we=%b want 0 0", cfg, t_req, t_we); end
        n_checks++; if (t_x1 !== 32'h0) begin n_errors++; $display("FAIL cfg%0d reset_x1: got %0h want 0", cfg, t_x1); end
    endtask

    task automatic test_li_outr();
        clear_img();
        img[0] = 32'h1305; img[1] = 32'h1400; img[2] = 32'h0F00;
        rand_mode = 1'b0;
        run_prog(100);
        n_checks++; if (t_halted !== 1'b1) begin n_errors++; $display("FAIL cfg%0d li_halted: got %b want 1", cfg, t_halted); end
        n_checks++; if (t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d li_pc: got %0h want %0h", cfg, t_pc, m_pc); end
        n_checks++; if (t_x1 !== m_x1) begin n_errors++; $display("FAIL cfg%0d li_x1: got %0h want %0h", cfg, t_x1, m_x1); end
        n_checks++; if (run_cyc !== int'(m_cycles)) begin n_errors++; $display("FAIL cfg%0d li_cycles: got %0d want %0d", cfg, run_cyc, m_cycles); end
        n_checks++;
        if (obs_q.size() != m_q.size()) begin n_errors++; $display("FAIL cfg%0d li_nout: got %0d want %0d", cfg, obs_q.size(), m_q.size()); end
        else foreach (m_q[i]) begin
            n_checks++; if (obs_q[i] !== m_q[i]) begin n_errors++; $display("FAIL cfg%0d li_out%0d: got %0h want %0h", cfg, i, obs_q[i], m_q[i]); end
        end
    endtask

    task automatic test_wait_states();
        clear_img();
        img[0] = 32'h017A; img[1] = 32'h0F00;
        rand_mode = 1'b1;
        run_prog(200);
        rand_mode = 1'b0;
        n_checks++; if (t_halted !== 1'b1) begin n_errors++; $display("FAIL cfg%0d ws_halted: got %b want 1", cfg, t_halted); end
        n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL cfg%0d ws_nout: got %0d want 1", cfg, obs_q.size()); end
        n_checks++; if (t_out !== 32'h7A) begin n_errors++; $display("FAIL cfg%0d ws_out: got %0h want 7a", cfg, t_out); end
        n_checks++; if (stab_err !== 0) begin n_errors++; $display("FAIL cfg%0d ws_stable: got %0d changes want 0", cfg, stab_err); end
    endtask

    task automatic test_loop();
        clear_img();
        img[0] = 32'h2303; img[1] = 32'h25FF; img[2] = 32'h2801; img[3] = 32'h0F00;
        rand_mode = 1'b0;
        run_prog(200);
        n_checks++; if (t_halted !== m_halted) begin n_errors++; $display("FAIL cfg%0d loop_halted: got %b want %b", cfg, t_halted, m_halted); end
        n_checks++; if (t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d loop_pc: got %0h want %0h", cfg, t_pc, m_pc); end
        n_checks++; if (run_cyc !== int'(m_cycles)) begin n_errors++; $display("FAIL cfg%0d loop_cycles: got %0d want %0d", cfg, run_cyc, m_cycles); end
    endtask

    task automatic test_addi_wrap();
        clear_img();
        img[0] = 32'h1300; img[1] = 32'h15FF; img[2] = 32'h1400;
        img[3] = 32'h1501; img[4] = 32'h1400; img[5] = 32'h0F00;
        rand_mode = 1'b0;
        run_prog(200);
        n_checks++; if (t_x1 !== m_x1) begin n_errors++; $display("FAIL cfg%0d wrap_x1: got %0h want %0h", cfg, t_x1, m_x1); end
        n_checks++;
        if (obs_q.size() != m_q.size()) begin n_errors++; $display("FAIL cfg%0d wrap_nout: got %0d want %0d", cfg, obs_q.size(), m_q.size()); end
        else foreach (m_q[i]) begin
            n_checks++; if (obs_q[i] !== m_q[i]) begin n_errors++; $display("FAIL cfg%0d wrap_out%0d: got %0h want %0h", cfg, i, obs_q[i], m_q[i]); end
        end
    endtask

    task automatic test_mem();
        logic [7:0] adr;
        adr = (cfg == 0) ? 8'h10 : 8'h0E;
        clear_img();
        img[0] = 32'h3342; img[1] = {16'h0, 8'h37, adr}; img[2] = {16'h0, 8'h46, adr};
        img[3] = 32'h4400; img[4] = {16'h0, 8'h02, adr}; img[5] = 32'h0F00;
        rand_mode = 1'b1;
        run_prog(400);
        rand_mode = 1'b0;
        n_checks++; if (t_halted !== 1'b1) begin n_errors++; $display("FAIL cfg%0d mem_halted: got %b want 1", cfg, t_halted); end
        n_checks++; if (wr_cnt !== 1) begin n_errors++; $display("FAIL cfg%0d mem_nwr: got %0d want 1", cfg, wr_cnt); end
        n_checks++; if (wr_addr !== 16'(adr)) begin n_errors++; $display("FAIL cfg%0d mem_wraddr: got %0h want %0h", cfg, wr_addr, adr); end
        n_checks++; if (wr_data !== 32'h42) begin n_errors++; $display("FAIL cfg%0d mem_wrdata: got %0h want 42", cfg, wr_data); end
        n_checks++; if (stab_err !== 0) begin n_errors++; $display("FAIL cfg%0d mem_stable: got %0d changes want 0", cfg, stab_err); end
        n_checks++;
        if (obs_q.size() != m_q.size()) begin n_errors++; $display("FAIL cfg%0d mem_nout: got %0d want %0d", cfg, obs_q.size(), m_q.size()); end
        else foreach (m_q[i]) begin
            n_checks++; if (obs_q[i] !== m_q[i]) begin n_errors++; $display("FAIL cfg%0d mem_out%0d: got %0h want %0h", cfg, i, obs_q[i], m_q[i]); end
        end
    endtask

    task automatic test_regidx();
        clear_img();
        img[0] = 32'h5333; img[1] = 32'h1400; img[2] = 32'h0F00;
        rand_mode = 1'b0;
        run_prog(100);
        n_checks++; if (t_x1 !== m_x1) begin n_errors++; $display("FAIL cfg%0d ridx_x1: got %0h want %0h", cfg, t_x1, m_x1); end
        n_checks++; if (t_out !== m_q[0]) begin n_errors++; $display("FAIL cfg%0d ridx_out: got %0h want %0h", cfg, t_out, m_q[0]); end
    endtask

    task automatic test_illegal();
        clear_img();
        img[0] = 32'h0B00; img[1] = 32'h0900;
        rand_mode = 1'b0;
        run_prog(8);
        n_checks++; if (t_illegal !== m_illegal) begin n_errors++; $display("FAIL cfg%0d ill_flag: got %b want %b", cfg, t_illegal, m_illegal); end
        n_checks++; if (t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d ill_pc: got %0h want %0h", cfg, t_pc, m_pc); end
        n_checks++; if (t_halted !== 1'b0) begin n_errors++; $display("FAIL cfg%0d ill_halted: got %b want 0", cfg, t_halted); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (t_illegal !== 1'b1) begin n_errors++; $display("FAIL cfg%0d ill_sticky: got %b want 1", cfg, t_illegal); end
        n_checks++; if (t_pc !== 16'h0) begin n_errors++; $display("FAIL cfg%0d ill_loop_pc: got %0h want 0", cfg, t_pc); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_img();
        img[0] = 32'h0705; img[1] = 32'h0F00;
        rand_mode = 1'b0;
        hold = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (t_state !== 3'd2 && k < 10) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        n_checks++; if (t_state !== 3'd2) begin n_errors++; $display("FAIL cfg%0d rmid_state: got %0d want 2", cfg, t_state); end
        n_checks++; if (t_req !== 1'b1 || t_we !== 1'b1 || t_addr !== 16'h5) begin n_errors++; $display("FAIL cfg%0d rmid_bus: got req=%b we=%b addr=%0h want 1 1 5", cfg, t_req, t_we, t_addr); end
        rst = 1'b1;
        #1;
        n_checks++; if (t_req !== 1'b0) begin n_errors++; $display("FAIL cfg%0d rmid_req: got %b want 0", cfg, t_req); end
        n_checks++; if (t_state !== 3'd0 || t_pc !== 16'h0) begin n_errors++; $display("FAIL cfg%0d rmid_rst: got state=%0d pc=%0h want 0 0", cfg, t_state, t_pc); end
        hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (t_req !== 1'b1 || t_we !== 1'b0 || t_addr !== 16'h0) begin n_errors++; $display("FAIL cfg%0d rmid_fetch: got req=%b we=%b addr=%0h want 1 0 0", cfg, t_req, t_we, t_addr); end
        n_checks++; if (wr_cnt !== 0 || t_out !== 32'h0 || t_outen !== 1'b0) begin n_errors++; $display("FAIL cfg%0d rmid_outs: got wr=%0d out=%0h outen=%b want 0 0 0", cfg, wr_cnt, t_out, t_outen); end
    endtask

    task automatic test_random();
        logic [3:0] ops [8];
        logic [3:0] op, r;
        logic [7:0] imm;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        for (int it = 0; it < 3; it++) begin
            clear_img();
            for (int i = 0; i < 12; i++) begin
                op  = ops[$urandom_range(0, 7)];
                r   = 4'($urandom_range(0, 15));
                imm = (op inside {4'h2, 4'h6, 4'h7}) ? 8'($urandom_range(13, 15)) : 8'($urandom_range(0, 255));
                img[i] = {16'h0, r, op, imm};
            end
            img[12] = 32'h0F00;
            rand_mode = 1'b1;
            run_prog(600);
            rand_mode = 1'b0;
            n_checks++; if (t_halted !== 1'b1 || t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d rnd%0d_end: got halted=%b pc=%0h want 1 %0h", cfg, it, t_halted, t_pc, m_pc); end
            n_checks++; if (t_x1 !== m_x1) begin n_errors++; $display("FAIL cfg%0d rnd%0d_x1: got %0h want %0h", cfg, it, t_x1, m_x1); end
            n_checks++; if (t_illegal !== m_illegal) begin n_errors++; $display("FAIL cfg%0d rnd%0d_ill: got %b want %b", cfg, it, t_illegal, m_illegal); end
            n_checks++; if (wr_cnt !== int'(m_wr)) begin n_errors++; $display("FAIL cfg%0d rnd%0d_nwr: got %0d want %0d", cfg, it, wr_cnt, m_wr); end
            if (m_wr > 0) begin
                n_checks++; if (wr_data !== m_wd || wr_addr !== 16'(m_wa)) begin n_errors++; $display("FAIL cfg%0d rnd%0d_wr: got %0h@%0h want %0h@%0h", cfg, it, wr_data, wr_addr, m_wd, m_wa); end
            end
            n_checks++; if (stab_err !== 0) begin n_errors++; $display("FAIL cfg%0d rnd%0d_stable: got %0d want 0", cfg, it, stab_err); end
            n_checks++;
            if (obs_q.size() != m_q.size()) begin n_errors++; $display("FAIL cfg%0d rnd%0d_nout: got %0d want %0d", cfg, it, obs_q.size(), m_q.size()); end
            else foreach (m_q[i]) begin
                n_checks++; if (obs_q[i] !== m_q[i]) begin n_errors++; $display("FAIL cfg%0d rnd%0d_out%0d: got %0h want %0h", cfg, it, i, obs_q[i], m_q[i]); end
            end
        end
    endtask

    task automatic test_pc_wrap();
        clear_img();
        rand_mode = 1'b0;
        run_prog(30);
        n_checks++; if (t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d wrap_pc15: got %0h want %0h", cfg, t_pc, m_pc); end
        model(32);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (t_pc !== 16'(m_pc)) begin n_errors++; $display("FAIL cfg%0d wrap_pc0: got %0h want %0h", cfg, t_pc, m_pc); end
    endtask

    initial begin
        clear_img();
        for (int c = 0; c < 2; c++) begin
            cfg = c;
            test_reset();
            test_li_outr();
            test_wait_states();
            test_loop();
            test_addi_wrap();
            test_mem();
            test_regidx();
            test_illegal();
            test_reset_mid();
            test_random();
        end
        cfg = 1;
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want completion before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
